// File: rtl/load_unit.sv
// RV32I load unit: effective-address formation, one aligned word read over a
// request/ready handshake, byte/half extraction with sign/zero extension, regfile writeback.
module load_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load_enable,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_value,
   input  logic [31:0] immediate12_load,
   input  logic [4:0]  rd_index,
   output logic        busy,
   output logic [31:0] memory_read_address,
   output logic        memory_read_request,
   input  logic        memory_read_ready,
   input  logic [31:0] memory_read_value,
   output logic        rd_write_enable,
   output logic [4:0]  rd_write_index,
   output logic [31:0] rd_write_value,
   output logic        load_fault,
   output logic [1:0]  fault_cause,
   output logic [31:0] fault_address
);
   // state | meaning
   // IDLE  | waiting for load_enable
   // REQ   | read request outstanding, timeout counter running
   // WB    | rd_write_enable strobe cycle
   // FAULT | load_fault strobe cycle
   typedef enum logic [1:0] {IDLE, REQ, WB, FAULT} state_t;

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t          state;
   logic [31:0]     ea;
   logic [31:0]     ea_q;
   logic [2:0]      funct3_q;
   logic [4:0]      rd_q;
   logic [CW-1:0]   timeout_count;
   logic            illegal;
   logic            misaligned;

   assign ea = rs1_value + immediate12_load;
   assign busy = (state != IDLE);

   always_comb begin
      illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      misaligned = 1'b0;
      case (funct3)
         3'd1, 3'd5: misaligned = ea[0];
         3'd2:       misaligned = (ea[1:0] != 2'b00);
         default:    misaligned = 1'b0;
      endcase
   end

   function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] off,
                                           input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (f)
         3'd0:    r = {{24{b[7]}}, b};
         3'd1:    r = {{16{h[15]}}, h};
         3'd4:    r = {24'd0, b};
         3'd5:    r = {16'd0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state               <= IDLE;
         ea_q                <= '0;
         funct3_q            <= '0;
         rd_q                <= '0;
         timeout_count       <= '0;
         memory_read_address <= '0;
         memory_read_request <= 1'b0;
         rd_write_enable     <= 1'b0;
         rd_write_index      <= '0;
         rd_write_value      <= '0;
         load_fault          <= 1'b0;
         fault_cause         <= '0;
         fault_address       <= '0;
      end else begin
         rd_write_enable <= 1'b0;
         load_fault      <= 1'b0;
         case (state)
            IDLE: begin
               if (load_enable) begin
                  ea_q          <= ea;
                  funct3_q      <= funct3;
                  rd_q          <= rd_index;
                  timeout_count <= '0;
                  // illegal funct3 is reported ahead of misalignment
                  if (illegal) begin
                     state         <= FAULT;
                     load_fault    <= 1'b1;
                     fault_cause   <= 2'd2;
                     fault_address <= ea;
                  end else if (misaligned) begin
                     state         <= FAULT;
                     load_fault    <= 1'b1;
                     fault_cause   <= 2'd1;
                     fault_address <= ea;
                  end else begin
                     state               <= REQ;
                     memory_read_request <= 1'b1;
                     memory_read_address <= {ea[31:2], 2'b00};
                  end
               end
            end
            REQ: begin
               if (memory_read_ready) begin
                  state               <= WB;
                  memory_read_request <= 1'b0;
                  rd_write_enable     <= (rd_q != 5'd0);
                  rd_write_index      <= rd_q;
                  rd_write_value      <= extract(funct3_q, ea_q[1:0], memory_read_value);
               end else if (timeout_count == COUNT_LAST) begin
                  state               <= FAULT;
                  memory_read_request <= 1'b0;
                  load_fault          <= 1'b1;
                  fault_cause         <= 2'd3;
                  fault_address       <= ea_q;
               end else begin
                  timeout_count <= timeout_count + 1'b1;
               end
            end
            WB:      state <= IDLE;
            FAULT:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: hand-computed load results, fault causes, timing,
// timeout, busy-ignore and reset-abort behaviour.
module tb_load_unit;
   logic        clock = 1'b0;
   logic        reset;
   logic        load_enable;
   logic [2:0]  funct3;
   logic [31:0] rs1_value;
   logic [31:0] immediate12_load;
   logic [4:0]  rd_index;
   logic        busy;
   logic [31:0] memory_read_address;
   logic        memory_read_request;
   logic        memory_read_ready;
   logic [31:0] memory_read_value;
   logic        rd_write_enable;
   logic [4:0]  rd_write_index;
   logic [31:0] rd_write_value;
   logic        load_fault;
   logic [1:0]  fault_cause;
   logic [31:0] fault_address;

   int check_count = 0;
   int pass_count  = 0;

   load_unit #(.TIMEOUT_CYCLES(16)) dut (
      .clock(clock), .reset(reset), .load_enable(load_enable), .funct3(funct3),
      .rs1_value(rs1_value), .immediate12_load(immediate12_load), .rd_index(rd_index),
      .busy(busy), .memory_read_address(memory_read_address),
      .memory_read_request(memory_read_request), .memory_read_ready(memory_read_ready),
      .memory_read_value(memory_read_value), .rd_write_enable(rd_write_enable),
      .rd_write_index(rd_write_index), .rd_write_value(rd_write_value),
      .load_fault(load_fault), .fault_cause(fault_cause), .fault_address(fault_address)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got === exp) pass_count++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start(input logic [2:0] f, input logic [31:0] base, input logic [31:0] imm,
                        input logic [4:0] rd);
      funct3 = f; rs1_value = base; immediate12_load = imm; rd_index = rd;
      load_enable = 1'b1;
      tick();
      load_enable = 1'b0;
   endtask

   // ready in the first REQ cycle: strobe two edges after acceptance
   task automatic run_load(input string tag, input logic [2:0] f, input logic [31:0] base,
                           input logic [31:0] imm, input logic [4:0] rd, input logic [31:0] data,
                           input logic [31:0] exp_addr, input logic exp_wen,
                           input logic [31:0] exp_val);
      start(f, base, imm, rd);
      check({tag, " req"}, 32'(memory_read_request), 32'd1);
      check({tag, " addr"}, memory_read_address, exp_addr);
      check({tag, " no early wen"}, 32'(rd_write_enable), 32'd0);
      memory_read_ready = 1'b1; memory_read_value = data;
      tick();
      memory_read_ready = 1'b0; memory_read_value = 32'h0;
      check({tag, " wen"}, 32'(rd_write_enable), 32'(exp_wen));
      check({tag, " req dropped"}, 32'(memory_read_request), 32'd0);
      if (exp_wen) begin
         check({tag, " index"}, 32'(rd_write_index), 32'(rd));
         check({tag, " value"}, rd_write_value, exp_val);
      end
      tick();
      check({tag, " wen one cycle"}, 32'(rd_write_enable), 32'd0);
      check({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   task automatic run_fault(input string tag, input logic [2:0] f, input logic [31:0] base,
                            input logic [31:0] imm, input logic [1:0] exp_cause,
                            input logic [31:0] exp_addr);
      start(f, base, imm, 5'd7);
      check({tag, " fault"}, 32'(load_fault), 32'd1);
      check({tag, " cause"}, 32'(fault_cause), 32'(exp_cause));
      check({tag, " faddr"}, fault_address, exp_addr);
      check({tag, " no req"}, 32'(memory_read_request), 32'd0);
      check({tag, " no wen"}, 32'(rd_write_enable), 32'd0);
      tick();
      check({tag, " fault one cycle"}, 32'(load_fault), 32'd0);
      check({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int high_cycles;
      reset = 1'b1; load_enable = 1'b0; funct3 = 3'd0; rs1_value = '0;
      immediate12_load = '0; rd_index = '0; memory_read_ready = 1'b0;
      memory_read_value = '0;
      tick(); tick();
      reset = 1'b0;
      check("reset busy", 32'(busy), 32'd0);
      check("reset req", 32'(memory_read_request), 32'd0);
      check("reset addr", memory_read_address, 32'd0);
      check("reset wen", 32'(rd_write_enable), 32'd0);
      check("reset fault", 32'(load_fault), 32'd0);
      check("reset wval", rd_write_value, 32'd0);

      run_load("lw",     3'd2, 32'h100, 32'h4, 5'd3, 32'hDEADBEEF, 32'h104, 1'b1, 32'hDEADBEEF);
      run_load("lb103",  3'd0, 32'h103, 32'h0, 5'd4, 32'h80FF1234, 32'h100, 1'b1, 32'hFFFFFF80);
      run_load("lbu103", 3'd4, 32'h103, 32'h0, 5'd5, 32'h80FF1234, 32'h100, 1'b1, 32'h00000080);
      run_load("lb101",  3'd0, 32'h100, 32'h1, 5'd6, 32'h80FF1234, 32'h100, 1'b1, 32'h00000012);
      run_load("lh102",  3'd1, 32'h102, 32'h0, 5'd8, 32'h80017FFF, 32'h100, 1'b1, 32'hFFFF8001);
      run_load("lhu100", 3'd5, 32'h104, 32'hFFFFFFFC, 5'd9, 32'h80017FFF, 32'h100, 1'b1,
               32'h00007FFF);
      run_load("lw wrap", 3'd2, 32'hFFFFFFFC, 32'h8, 5'd31, 32'h0BADF00D, 32'h4, 1'b1,
               32'h0BADF00D);
      run_load("rd0",    3'd2, 32'h200, 32'h0, 5'd0, 32'h12345678, 32'h200, 1'b0, 32'h0);

      run_fault("lw mis",   3'd2, 32'h102, 32'h0, 2'd1, 32'h102);
      run_fault("lh mis",   3'd1, 32'h100, 32'h1, 2'd1, 32'h101);
      run_fault("f3 3",     3'd3, 32'h102, 32'h0, 2'd2, 32'h102);
      run_fault("f3 7 mis", 3'd7, 32'h100, 32'h3, 2'd2, 32'h103);

      // load_enable while in REQ must not restart or fault
      start(3'd2, 32'h300, 32'h0, 5'd10);
      funct3 = 3'd3; rs1_value = 32'h401; rd_index = 5'd11; load_enable = 1'b1;
      tick();
      load_enable = 1'b0;
      check("busy ign fault", 32'(load_fault), 32'd0);
      check("busy ign req", 32'(memory_read_request), 32'd1);
      check("busy ign addr", memory_read_address, 32'h300);
      memory_read_ready = 1'b1; memory_read_value = 32'hCAFEF00D;
      tick();
      memory_read_ready = 1'b0;
      check("busy ign index", 32'(rd_write_index), 32'd10);
      check("busy ign value", rd_write_value, 32'hCAFEF00D);
      tick();
      check("busy ign idle", 32'(busy), 32'd0);

      // timeout: request stays high exactly 16 cycles
      start(3'd2, 32'h500, 32'h8, 5'd12);
      high_cycles = 0;
      for (int i = 0; i < 40 && memory_read_request; i++) begin
         high_cycles++;
         if (load_fault) break;
         tick();
      end
      check("timeout req cycles", 32'(high_cycles), 32'd16);
      check("timeout req low", 32'(memory_read_request), 32'd0);
      check("timeout fault", 32'(load_fault), 32'd1);
      check("timeout cause", 32'(fault_cause), 32'd3);
      check("timeout faddr", fault_address, 32'h508);
      check("timeout no wen", 32'(rd_write_enable), 32'd0);
      tick();
      check("timeout idle", 32'(busy), 32'd0);

      // reset during REQ aborts cleanly
      start(3'd2, 32'h600, 32'h0, 5'd13);
      check("abort req", 32'(memory_read_request), 32'd1);
      reset = 1'b1; memory_read_ready = 1'b1; memory_read_value = 32'h11111111;
      tick();
      reset = 1'b0; memory_read_ready = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort req low", 32'(memory_read_request), 32'd0);
      check("abort no wen", 32'(rd_write_enable), 32'd0);
      check("abort no fault", 32'(load_fault), 32'd0);
      tick();
      check("abort still idle", 32'(busy), 32'd0);
      check("abort still no wen", 32'(rd_write_enable), 32'd0);

      // unit still works after the abort
      run_load("post abort", 3'd4, 32'h700, 32'h2, 5'd14, 32'h00A50000, 32'h700, 1'b1,
               32'h000000A5);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule
